// File: rtl/cpu_seq_pkg.sv
// Shared types and opcode constants for the fetch/decode/execute sequencer.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    MWAIT  = 3'd5,
    WB     = 3'd6,
    HALT   = 3'd7
  } state_t;

  localparam logic [3:0] OP_FWD_IMM = 4'd0;
  localparam logic [3:0] OP_FWD_REG = 4'd1;
  localparam logic [3:0] OP_ADD     = 4'd2;
  localparam logic [3:0] OP_SUB     = 4'd3;
  localparam logic [3:0] OP_AND     = 4'd4;
  localparam logic [3:0] OP_OR      = 4'd5;
  localparam logic [3:0] OP_LOAD    = 4'd6;
  localparam logic [3:0] OP_STORE   = 4'd7;
  localparam logic [3:0] OP_HALT    = 4'd15;

  function automatic logic is_alu(input logic [3:0] op);
    return (op <= OP_OR);
  endfunction

endpackage

// File: rtl/cpu_seq_pc.sv
// Program counter: advances by PC_STEP when enabled, wrapping modulo 2**PC_W.
module cpu_seq_pc #(
  parameter int PC_W    = 9,
  parameter int PC_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  output logic [PC_W-1:0] pc
);

  // PC register; the add truncates to PC_W bits so the top address wraps to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
    end else if (advance) begin
      pc <= pc + PC_W'(PC_STEP);
    end else begin
      pc <= pc;
    end
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 9-bit CPU datapath.
// Optional build macro CPU_SEQ_PERF_EN adds a saturating retired-instruction counter.
module cpu_seq_ctrl
  import cpu_seq_pkg::*;
#(
  parameter int PC_W     = 9,
  parameter int INSTR_W  = 9,
  parameter int PC_STEP  = 4,
  parameter int MEM_WAIT = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic               write_en,
  output logic               CS,
  output logic               RD,
  output logic               busy,
  output logic               halted,
`ifdef CPU_SEQ_PERF_EN
  output logic [15:0]        retired,
`endif
  output logic               illegal
);

  localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       op;
  logic             advance;
  logic             set_illegal;
  logic             start_ok;
  logic [CNT_W-1:0] wait_cnt;

  assign op       = instr[4:1];
  assign start_ok = start && ((state == IDLE) || (state == HALT));

  cpu_seq_pc #(
    .PC_W    (PC_W),
    .PC_STEP (PC_STEP)
  ) u_pc (
    .clk     (CLK),
    .rst     (RESET),
    .advance (advance),
    .pc      (pc)
  );

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and PC-advance decode
  always_comb begin
    state_nxt   = state;
    advance     = 1'b0;
    set_illegal = 1'b0;
    case (state)
      IDLE, HALT: begin
        if (start) state_nxt = FETCH;
        else       state_nxt = state;
      end
      FETCH: begin
        if (imem_valid) state_nxt = DECODE;
        else            state_nxt = FETCH;
      end
      DECODE: begin
        if (is_alu(op)) begin
          state_nxt = EXEC;
        end else if ((op == OP_LOAD) || (op == OP_STORE)) begin
          state_nxt = MEM;
        end else if (op == OP_HALT) begin
          state_nxt = HALT;
        end else begin
          // undefined opcode: flag it and skip to the next instruction
          set_illegal = 1'b1;
          advance     = 1'b1;
          state_nxt   = FETCH;
        end
      end
      EXEC: begin
        advance   = 1'b1;
        state_nxt = FETCH;
      end
      MEM: begin
        if (op == OP_STORE) begin
          advance   = 1'b1;
          state_nxt = FETCH;
        end else begin
          state_nxt = MWAIT;
        end
      end
      MWAIT: begin
        if (wait_cnt == '0) state_nxt = WB;
        else                state_nxt = MWAIT;
      end
      WB: begin
        advance   = 1'b1;
        state_nxt = FETCH;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // SRAM wait counter, loaded on entry to MWAIT
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wait_cnt <= '0;
    end else if (state == MEM) begin
      wait_cnt <= CNT_W'(MEM_WAIT - 1);
    end else if ((state == MWAIT) && (wait_cnt != '0)) begin
      wait_cnt <= wait_cnt - CNT_W'(1);
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Instruction latch: only an accepted fetch updates it
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      instr <= '0;
    end else if ((state == FETCH) && imem_valid) begin
      instr <= imem_rdata;
    end else begin
      instr <= instr;
    end
  end

  // Sticky illegal-opcode flag
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      illegal <= 1'b0;
    end else if (start_ok) begin
      illegal <= 1'b0;
    end else if (set_illegal) begin
      illegal <= 1'b1;
    end else begin
      illegal <= illegal;
    end
  end

`ifdef CPU_SEQ_PERF_EN
  // Saturating count of completed EXEC / STORE / WB phases
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      retired <= 16'h0000;
    end else if (((state == EXEC) || (state == WB) ||
                  ((state == MEM) && (op == OP_STORE))) && (retired != 16'hFFFF)) begin
      retired <= retired + 16'h0001;
    end else begin
      retired <= retired;
    end
  end
`endif

  // Strobes decode straight from the state flops, so RESET drops them at once
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign write_en  = (state == EXEC) || (state == WB);
  assign CS        = (state == MEM) || (state == MWAIT);
  assign RD        = ((state == MEM) && (op == OP_LOAD)) || (state == MWAIT);
  assign busy      = (state != IDLE) && (state != HALT);
  assign halted    = (state == HALT);

endmodule
